// File: rtl/hazard_pkg.sv
// Shared types for the issue-stage hazard scoreboard.
// Optional load bypass is selected with HAZ_LD_BYPASS_EN.
package hazard_pkg;

    localparam int ADDR_W = 5;
    localparam int NREGS  = 1 << ADDR_W;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_sel_e;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd;
        logic              fwd_ok;
    } slot_t;

endpackage

// File: rtl/hazard_if.sv
// Decode-side bundle: instruction fields in, stall/issue/forwarding out.
// Master is the decode stage, slave is the scoreboard.
interface hazard_if;
    import hazard_pkg::*;

    logic              id_valid;
    logic [ADDR_W-1:0] id_rs1;
    logic [ADDR_W-1:0] id_rs2;
    logic [ADDR_W-1:0] id_rd;
    logic              id_rd_we;
    logic              id_is_load;
    logic              id_stall;
    logic              id_issue;
    fwd_sel_e          fwd_sel_a;
    fwd_sel_e          fwd_sel_b;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd,
        output id_rd_we, id_is_load,
        input  id_stall, id_issue,
        input  fwd_sel_a, fwd_sel_b
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd,
        input  id_rd_we, id_is_load,
        output id_stall, id_issue,
        output fwd_sel_a, fwd_sel_b
    );

endinterface

// File: rtl/hazard_scoreboard_addr_match.sv
// Register-address compare; r0 never matches anything.
// Shared by every slot/operand and bypass comparison.
module addr_match
    import hazard_pkg::*;
(
    input  logic [ADDR_W-1:0] a,
    input  logic [ADDR_W-1:0] b,
    output logic              hit
);

    assign hit = (a == b) && (a != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue hazard controller: EX/MEM/WB forwarding plus load busy scoreboard.
// Define HAZ_LD_BYPASS_EN to let ld_done release a stall in the same cycle.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int MAX_PEND = 4
)
(
    input  logic              clk,
    input  logic              rst_n,
    hazard_if.slave           id,
    input  logic              ld_done,
    input  logic [ADDR_W-1:0] ld_done_rd,
    input  logic              flush,
    output logic [3:0]        pend_cnt,
    output logic              sb_err
);

    slot_t             ex_q, ex_d;
    slot_t             mem_q, mem_d;
    slot_t             wb_q, wb_d;
    logic [NREGS-1:0]  busy_q, busy_d;
    logic [3:0]        pend_q, pend_d;
    logic              err_q, err_d;

    slot_t             slots [3];
    logic [2:0]        hit_a, hit_b;
    logic [2:0]        use_a, use_b;
    fwd_sel_e          sel_a, sel_b;

    logic              mask_rs1, mask_rs2, mask_rd;
    logic              raw, waw, full;
    logic              stall, issue;
    logic              set_busy, clr_busy;

    assign slots[0] = ex_q;
    assign slots[1] = mem_q;
    assign slots[2] = wb_q;

    for (genvar i = 0; i < 3; i++) begin : g_fwd
        addr_match u_a (
            .a   (id.id_rs1),
            .b   (slots[i].rd),
            .hit (hit_a[i])
        );
        addr_match u_b (
            .a   (id.id_rs2),
            .b   (slots[i].rd),
            .hit (hit_b[i])
        );
        assign use_a[i] = slots[i].valid & slots[i].fwd_ok & hit_a[i];
        assign use_b[i] = slots[i].valid & slots[i].fwd_ok & hit_b[i];
    end

    // Youngest producer wins.
    always_comb begin
        sel_a = FWD_RF;
        if (use_a[0])      sel_a = FWD_EX;
        else if (use_a[1]) sel_a = FWD_MEM;
        else if (use_a[2]) sel_a = FWD_WB;
        sel_b = FWD_RF;
        if (use_b[0])      sel_b = FWD_EX;
        else if (use_b[1]) sel_b = FWD_MEM;
        else if (use_b[2]) sel_b = FWD_WB;
    end

`ifdef HAZ_LD_BYPASS_EN
    logic byp_rs1, byp_rs2, byp_rd;

    addr_match u_byp_rs1 (
        .a   (ld_done_rd),
        .b   (id.id_rs1),
        .hit (byp_rs1)
    );
    addr_match u_byp_rs2 (
        .a   (ld_done_rd),
        .b   (id.id_rs2),
        .hit (byp_rs2)
    );
    addr_match u_byp_rd (
        .a   (ld_done_rd),
        .b   (id.id_rd),
        .hit (byp_rd)
    );

    // Regfile write-through supplies the value this cycle.
    assign mask_rs1 = ld_done & byp_rs1;
    assign mask_rs2 = ld_done & byp_rs2;
    assign mask_rd  = ld_done & byp_rd;
`else
    assign mask_rs1 = 1'b0;
    assign mask_rs2 = 1'b0;
    assign mask_rd  = 1'b0;
`endif

    always_comb begin
        raw   = (busy_q[id.id_rs1] & ~mask_rs1)
              | (busy_q[id.id_rs2] & ~mask_rs2);
        waw   = id.id_rd_we & busy_q[id.id_rd] & ~mask_rd;
        full  = id.id_is_load & (pend_q == 4'(MAX_PEND));
        stall = id.id_valid & ~flush & (raw | waw | full);
        issue = id.id_valid & ~flush & ~stall;
    end

    always_comb begin
        set_busy = issue & id.id_is_load & id.id_rd_we
                 & (id.id_rd != '0);
        clr_busy = ld_done & busy_q[ld_done_rd];

        busy_d = busy_q;
        if (clr_busy) busy_d[ld_done_rd] = 1'b0;
        // Set after clear: a same-register reissue stays busy.
        if (set_busy) busy_d[id.id_rd] = 1'b1;

        pend_d = pend_q + {3'b0, set_busy} - {3'b0, clr_busy};
        err_d  = err_q | (ld_done & ~busy_q[ld_done_rd]);

        ex_d = '0;
        if (issue) begin
            ex_d.valid  = 1'b1;
            ex_d.rd     = id.id_rd;
            ex_d.fwd_ok = id.id_rd_we & ~id.id_is_load;
        end
        mem_d = flush ? '0 : ex_q;
        wb_d  = mem_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q   <= '0;
            mem_q  <= '0;
            wb_q   <= '0;
            busy_q <= '0;
            pend_q <= '0;
            err_q  <= 1'b0;
        end else begin
            ex_q   <= ex_d;
            mem_q  <= mem_d;
            wb_q   <= wb_d;
            busy_q <= busy_d;
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    assign id.id_stall  = stall;
    assign id.id_issue  = issue;
    assign id.fwd_sel_a = sel_a;
    assign id.fwd_sel_b = sel_b;
    assign pend_cnt     = pend_q;
    assign sb_err       = err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus a random run
// against an instruction-history / outstanding-load-list model.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int MAXP = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ld_done;
    logic [ADDR_W-1:0] ld_done_rd;
    logic              flush;
    logic [3:0]        pend_cnt;
    logic              sb_err;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_if hif ();

    hazard_scoreboard #(.MAX_PEND(MAXP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id         (hif),
        .ld_done    (ld_done),
        .ld_done_rd (ld_done_rd),
        .flush      (flush),
        .pend_cnt   (pend_cnt),
        .sb_err     (sb_err)
    );

    always #5 clk = ~clk;

    // Model: last three issue decisions (youngest first) and the
    // list of registers with a load still outstanding.
    typedef struct {
        bit v;
        int rd;
        bit fok;
    } hrec_t;

    hrec_t hist [3];
    int    outq [$];
    bit    m_err;

    function automatic void m_reset();
        for (int k = 0; k < 3; k++) hist[k] = '{0, 0, 0};
        outq.delete();
        m_err = 0;
    endfunction

    function automatic bit m_busy(int r);
        foreach (outq[i]) if (outq[i] == r) return 1;
        return 0;
    endfunction

    function automatic int m_fwd(int rs);
        if (rs == 0) return 0;
        for (int k = 0; k < 3; k++)
            if (hist[k].v && hist[k].fok && hist[k].rd == rs)
                return k + 1;
        return 0;
    endfunction

    function automatic bit m_blocked(int r);
        bit b;
        b = m_busy(r);
`ifdef HAZ_LD_BYPASS_EN
        if (ld_done && int'(ld_done_rd) == r && r != 0) b = 0;
`endif
        return b;
    endfunction

    function automatic bit m_stall();
        bit h;
        h = m_blocked(int'(hif.id_rs1)) || m_blocked(int'(hif.id_rs2))
          || (hif.id_rd_we && m_blocked(int'(hif.id_rd)))
          || (hif.id_is_load && outq.size() == MAXP);
        return hif.id_valid && !flush && h;
    endfunction

    function automatic void m_update();
        bit iss;
        int idx;
        iss = hif.id_valid && !flush && !m_stall();
        if (ld_done) begin
            idx = -1;
            foreach (outq[i]) if (outq[i] == int'(ld_done_rd)) idx = i;
            if (idx >= 0) outq.delete(idx);
            else m_err = 1;
        end
        if (iss && hif.id_is_load && hif.id_rd_we && hif.id_rd != 0)
            outq.push_back(int'(hif.id_rd));
        hist[2] = hist[1];
        hist[1] = flush ? '{0, 0, 0} : hist[0];
        if (iss)
            hist[0] = '{1, int'(hif.id_rd),
                        hif.id_rd_we && !hif.id_is_load};
        else
            hist[0] = '{0, 0, 0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int rs1, input int rs2,
                         input int rd, input logic we, input logic ld);
        hif.id_valid   = v;
        hif.id_rs1     = ADDR_W'(rs1);
        hif.id_rs2     = ADDR_W'(rs2);
        hif.id_rd      = ADDR_W'(rd);
        hif.id_rd_we   = we;
        hif.id_is_load = ld;
    endtask

    task automatic done(input logic d, input int r);
        ld_done    = d;
        ld_done_rd = ADDR_W'(r);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0);
        done(0, 0);
        flush = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        m_reset();
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        #1;
        n_tests++;
        if (pend_cnt !== 4'd0 || sb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state pend=%0d err=%b want 0 0",
                     pend_cnt, sb_err);
        end
        n_tests++;
        if (hif.id_stall !== 1'b0 || hif.id_issue !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctl stall=%b issue=%b want 0 0",
                     hif.id_stall, hif.id_issue);
        end
        n_tests++;
        if (hif.fwd_sel_a !== FWD_RF || hif.fwd_sel_b !== FWD_RF) begin
            n_fail++;
            $display("FAIL reset_fwd a=%0d b=%0d want 0 0",
                     hif.fwd_sel_a, hif.fwd_sel_b);
        end
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_forwarding();
        fwd_sel_e exp_g [4];
        exp_g = '{FWD_EX, FWD_MEM, FWD_WB, FWD_RF};
        do_reset();
        for (int gap = 0; gap < 4; gap++) begin
            idle();
            tick(); tick(); tick();
            drive(1, 1, 2, 3, 1, 0);
            tick();
            idle();
            for (int g = 0; g < gap; g++) tick();
            drive(1, 3, 0, 4, 1, 0);
            #1;
            n_tests++;
            if (hif.fwd_sel_a !== exp_g[gap] ||
                hif.fwd_sel_b !== FWD_RF) begin
                n_fail++;
                $display("FAIL fwd_gap%0d a=%0d b=%0d want %0d 0",
                         gap, hif.fwd_sel_a, hif.fwd_sel_b,
                         exp_g[gap]);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_load_stall();
        do_reset();
        drive(1, 0, 0, 5, 1, 1);
        tick();
        drive(1, 0, 5, 6, 1, 0);
        #1;
        n_tests++;
        if (hif.id_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL ld_raw_stall got %b want 1", hif.id_stall);
        end
        tick();
        tick();
        n_tests++;
        if (hif.id_stall !== 1'b1 || pend_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL ld_raw_hold stall=%b pend=%0d want 1 1",
                     hif.id_stall, pend_cnt);
        end
        done(1, 5);
        #1;
`ifdef HAZ_LD_BYPASS_EN
        n_tests++;
        if (hif.id_stall !== 1'b0 || hif.id_issue !== 1'b1) begin
            n_fail++;
            $display("FAIL ld_bypass stall=%b issue=%b want 0 1",
                     hif.id_stall, hif.id_issue);
        end
        tick();
        idle();
`else
        n_tests++;
        if (hif.id_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL ld_done_cycle stall=%b want 1",
                     hif.id_stall);
        end
        tick();
        done(0, 0);
        #1;
        n_tests++;
        if (hif.id_stall !== 1'b0 || hif.id_issue !== 1'b1) begin
            n_fail++;
            $display("FAIL ld_after_done stall=%b issue=%b want 0 1",
                     hif.id_stall, hif.id_issue);
        end
        tick();
        idle();
`endif
        #1;
        n_tests++;
        if (pend_cnt !== 4'd0 || sb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL ld_drain pend=%0d err=%b want 0 0",
                     pend_cnt, sb_err);
        end
    endtask

    task automatic test_max_pend();
        int drain [4];
        drain = '{1, 3, 4, 6};
        do_reset();
        for (int r = 1; r <= 4; r++) begin
            drive(1, 0, 0, r, 1, 1);
            tick();
        end
        drive(1, 0, 0, 6, 1, 1);
        #1;
        n_tests++;
        if (hif.id_stall !== 1'b1 || pend_cnt !== 4'd4) begin
            n_fail++;
            $display("FAIL max_full stall=%b pend=%0d want 1 4",
                     hif.id_stall, pend_cnt);
        end
        tick();
        done(1, 2);
        #1;
        n_tests++;
        if (hif.id_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL max_done_cycle stall=%b want 1",
                     hif.id_stall);
        end
        tick();
        done(0, 0);
        #1;
        n_tests++;
        if (hif.id_issue !== 1'b1 || pend_cnt !== 4'd3) begin
            n_fail++;
            $display("FAIL max_issue issue=%b pend=%0d want 1 3",
                     hif.id_issue, pend_cnt);
        end
        tick();
        idle();
        n_tests++;
        if (pend_cnt !== 4'd4) begin
            n_fail++;
            $display("FAIL max_refill pend=%0d want 4", pend_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            done(1, drain[i]);
            tick();
        end
        done(0, 0);
        n_tests++;
        if (pend_cnt !== 4'd0 || sb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL max_drain pend=%0d err=%b want 0 0",
                     pend_cnt, sb_err);
        end
    endtask

    task automatic test_r0();
        do_reset();
        drive(1, 0, 0, 0, 1, 0);
        tick();
        drive(1, 0, 0, 8, 1, 0);
        #1;
        n_tests++;
        if (hif.fwd_sel_a !== FWD_RF || hif.id_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL r0_fwd a=%0d stall=%b want 0 0",
                     hif.fwd_sel_a, hif.id_stall);
        end
        tick();
        drive(1, 1, 0, 0, 1, 1);
        tick();
        drive(1, 0, 0, 0, 1, 0);
        #1;
        n_tests++;
        if (pend_cnt !== 4'd0 || hif.id_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL r0_load pend=%0d stall=%b want 0 0",
                     pend_cnt, hif.id_stall);
        end
        tick();
        idle();
    endtask

    task automatic test_sb_err_reset();
        do_reset();
        done(1, 7);
        tick();
        done(0, 0);
        tick();
        n_tests++;
        if (sb_err !== 1'b1 || pend_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL sb_err err=%b pend=%0d want 1 0",
                     sb_err, pend_cnt);
        end
        drive(1, 0, 0, 5, 1, 1);
        tick();
        drive(1, 5, 0, 9, 1, 0);
        #1;
        rst_n = 0;
        #1;
        n_tests++;
        if (sb_err !== 1'b0 || pend_cnt !== 4'd0 ||
            hif.id_stall !== 1'b0 || hif.fwd_sel_a !== FWD_RF) begin
            n_fail++;
            $display("FAIL async_rst err=%b pend=%0d stall=%b a=%0d",
                     sb_err, pend_cnt, hif.id_stall, hif.fwd_sel_a);
        end
        tick();
        rst_n = 1;
        idle();
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        drive(1, 0, 0, 5, 1, 1);
        tick();
        drive(1, 0, 0, 9, 1, 0);
        tick();
        drive(1, 5, 0, 10, 1, 0);
        flush = 1;
        #1;
        n_tests++;
        if (hif.id_stall !== 1'b0 || hif.id_issue !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_ctl stall=%b issue=%b want 0 0",
                     hif.id_stall, hif.id_issue);
        end
        tick();
        flush = 0;
        drive(1, 9, 5, 11, 1, 0);
        #1;
        n_tests++;
        if (hif.fwd_sel_a !== FWD_RF || hif.id_stall !== 1'b1 ||
            pend_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL flush_after a=%0d stall=%b pend=%0d",
                     hif.fwd_sel_a, hif.id_stall, pend_cnt);
        end
        idle();
        done(1, 5);
        tick();
        done(0, 0);
        n_tests++;
        if (pend_cnt !== 4'd0 || sb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_drain pend=%0d err=%b want 0 0",
                     pend_cnt, sb_err);
        end
    endtask

    task automatic test_random();
        bit          es;
        logic [1:0]  ea, eb;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            drive($urandom_range(0, 9) < 8,
                  $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7),
                  $urandom_range(0, 9) < 8,
                  $urandom_range(0, 9) < 3);
            flush = ($urandom_range(0, 19) == 0);
            if (outq.size() > 0 && $urandom_range(0, 9) < 4)
                done(1, outq[$urandom_range(0, outq.size() - 1)]);
            else if ($urandom_range(0, 299) == 0)
                done(1, $urandom_range(0, 7));
            else
                done(0, 0);
            #1;
            es = m_stall();
            ea = 2'(m_fwd(int'(hif.id_rs1)));
            eb = 2'(m_fwd(int'(hif.id_rs2)));
            n_tests++;
            if (hif.id_stall !== es ||
                hif.id_issue !== (hif.id_valid & ~flush & ~es)) begin
                n_fail++;
                $display("FAIL rnd_stall c=%0d stall=%b issue=%b want %b",
                         c, hif.id_stall, hif.id_issue, es);
            end
            n_tests++;
            if (2'(hif.fwd_sel_a) !== ea || 2'(hif.fwd_sel_b) !== eb) begin
                n_fail++;
                $display("FAIL rnd_fwd c=%0d a=%0d b=%0d want %0d %0d",
                         c, hif.fwd_sel_a, hif.fwd_sel_b, ea, eb);
            end
            n_tests++;
            if (pend_cnt !== 4'(outq.size()) || sb_err !== m_err) begin
                n_fail++;
                $display("FAIL rnd_sb c=%0d pend=%0d err=%b want %0d %b",
                         c, pend_cnt, sb_err, outq.size(), m_err);
            end
            m_update();
            tick();
        end
        idle();
    endtask

    initial begin
        m_reset();
        test_reset();
        test_forwarding();
        test_load_stall();
        test_max_pend();
        test_r0();
        test_sb_err_reset();
        test_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
